// File: rtl/distribuir_mem_local_rtc_burst_if.sv
// rtl/distribuir_mem_local_rtc_burst_if.sv - word/ack handshake toward the RTC write controller
interface distribuir_mem_local_rtc_burst_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] out_dato;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              in_ack;

    modport master (output out_dato, output out_addr, output out_valid, input in_ack);
    modport slave  (input out_dato, input out_addr, input out_valid, output in_ack);
endinterface

// File: rtl/distribuir_mem_local_rtc_burst.sv
// rtl/distribuir_mem_local_rtc_burst.sv - sequences masked/single local registers onto the RTC write path
module distribuir_mem_local_rtc_burst #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 10,
    parameter int ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       modo_unico,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [NUM_REGS-1:0]        mascara,
    input  logic [NUM_REGS*DATA_W-1:0] in_datos_flat,
    distribuir_mem_local_rtc_burst_if.master rtc,
    output logic                       ocupado,
    output logic                       fin,
    output logic                       error_addr
);
    typedef enum logic [1:0] {IDLE, BUSCAR, PRESENTAR, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic                single_q, single_d;
    logic [DATA_W-1:0]   dato_q, dato_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == ADDR_W'(i)) sel_data = in_datos_flat[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            single_q <= 1'b0;
            dato_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            single_q <= single_d;
            dato_q   <= dato_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        single_d = single_q;
        dato_d   = dato_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (!modo_unico) begin
                        mask_d   = mascara;
                        idx_d    = '0;
                        single_d = 1'b0;
                        state_d  = BUSCAR;
                    end else if (in_addr <= LAST_IDX) begin
                        mask_d   = NUM_REGS'(1) << in_addr;
                        idx_d    = in_addr;
                        single_d = 1'b1;
                        state_d  = BUSCAR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            BUSCAR: begin
                if (mask_q[idx_q]) begin
                    dato_d  = sel_data;
                    addr_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = PRESENTAR;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PRESENTAR: begin
                // Word is frozen in dato_q until acknowledged; live input changes are not seen.
                if (rtc.in_ack) begin
                    valid_d = 1'b0;
                    dato_d  = '0;
                    if (single_q || idx_q == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = BUSCAR;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rtc.out_dato  = dato_q;
    assign rtc.out_addr  = addr_q;
    assign rtc.out_valid = valid_q;
    assign ocupado       = (state_q != IDLE);
    assign fin           = (state_q == FIN);
    assign error_addr    = err_q;
endmodule

// File: tb/tb_distribuir_mem_local_rtc_burst.sv
// tb/tb_distribuir_mem_local_rtc_burst.sv - directed scoreboard bench for distribuir_mem_local_rtc_burst
module tb_distribuir_mem_local_rtc_burst;
    localparam int DW = 8;
    localparam int NR = 10;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            modo_unico;
    logic [AW-1:0]   in_addr;
    logic [NR-1:0]   mascara;
    logic [NR*DW-1:0] in_datos_flat;
    logic [NR*DW-1:0] base;
    logic            ocupado;
    logic            fin;
    logic            error_addr;

    distribuir_mem_local_rtc_burst_if #(.DATA_W(DW), .ADDR_W(AW)) rtc ();

    distribuir_mem_local_rtc_burst #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .modo_unico    (modo_unico),
        .in_addr       (in_addr),
        .mascara       (mascara),
        .in_datos_flat (in_datos_flat),
        .rtc           (rtc),
        .ocupado       (ocupado),
        .fin           (fin),
        .error_addr    (error_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int words  = 0;
    int fins   = 0;
    int ack_mode = 2;   // 0 tied high, 1 ack 3 cycles after valid with data toggling, 2 low, 3 manual
    bit spacing_on = 1'b0;
    bit first_word = 1'b1;
    logic [AW+DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / protocol monitor
    initial begin
        logic            prev_valid;
        logic [DW-1:0]   held_dato;
        logic [AW-1:0]   held_addr;
        logic [AW+DW-1:0] exp_w;
        int              last_rise;
        int              run;
        prev_valid = 1'b0; held_dato = '0; held_addr = '0; last_rise = 0; run = 0;
        forever begin
            @(negedge clk);
            if (fin) fins++;
            if (rtc.out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(rtc.out_addr), 32'hFFFF);
                end else begin
                    exp_w = sb.pop_front();
                    chk("word_addr", 32'(rtc.out_addr), 32'(exp_w[AW+DW-1:DW]));
                    chk("word_data", 32'(rtc.out_dato), 32'(exp_w[DW-1:0]));
                end
                if (spacing_on && !first_word) chk("word_spacing", 32'(cyc - last_rise), 2);
                first_word = 1'b0;
                last_rise = cyc;
                held_dato = rtc.out_dato;
                held_addr = rtc.out_addr;
                run = 1;
                words++;
            end else if (rtc.out_valid) begin
                chk("hold_data", 32'(rtc.out_dato), 32'(held_dato));
                chk("hold_addr", 32'(rtc.out_addr), 32'(held_addr));
                run++;
            end else if (prev_valid && spacing_on) begin
                chk("valid_len", 32'(run), 1);
            end
            if (!rtc.out_valid) chk("dato_zero", 32'(rtc.out_dato), 0);
            prev_valid = rtc.out_valid;
        end
    end

    // RTC write controller model
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            case (ack_mode)
                0: rtc.in_ack = 1'b1;
                1: begin
                    if (rtc.out_valid) begin
                        cnt++;
                        if (cnt >= 3) begin
                            rtc.in_ack = 1'b1;
                            in_datos_flat = base;
                        end else begin
                            rtc.in_ack = 1'b0;
                            in_datos_flat = ~base;
                        end
                    end else begin
                        cnt = 0;
                        rtc.in_ack = 1'b0;
                    end
                end
                2: rtc.in_ack = 1'b0;
                default: ;
            endcase
        end
    end

    task automatic push_burst(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++)
            if (m[i]) sb.push_back({AW'(i), base[i*DW +: DW]});
    endtask

    task automatic run_start(input bit single, input logic [AW-1:0] a, input logic [NR-1:0] m);
        @(negedge clk);
        modo_unico = single;
        in_addr = a;
        mascara = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_fin(input string tag, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (fin) break;
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk({tag, "_fin_timeout"}, 1, 0);
    endtask

    initial begin
        int n, w0, f0;
        reset = 1'b1; start = 1'b0; modo_unico = 1'b0; in_addr = '0; mascara = '0;
        rtc.in_ack = 1'b0;
        for (int i = 0; i < NR; i++) base[i*DW +: DW] = DW'(8'h10 + i);
        in_datos_flat = base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rtc.out_valid), 0);
        chk("rst_dato", 32'(rtc.out_dato), 0);
        chk("rst_addr", 32'(rtc.out_addr), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_fin", 32'(fin), 0);
        chk("rst_err", 32'(error_addr), 0);
        @(negedge clk); reset = 1'b0;

        // 1: reset while a word is presented
        ack_mode = 2;
        sb.push_back({AW'(0), base[DW-1:0]});
        run_start(1'b0, '0, 10'h3FF);
        chk("t1_ocupado", 32'(ocupado), 1);
        n = 0;
        while (!rtc.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("t1_valid_seen", 32'(rtc.out_valid), 1);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("t1_valid", 32'(rtc.out_valid), 0);
        chk("t1_dato", 32'(rtc.out_dato), 0);
        chk("t1_addr", 32'(rtc.out_addr), 0);
        chk("t1_ocupado", 32'(ocupado), 0);
        chk("t1_fin", 32'(fin), 0);
        @(negedge clk); reset = 1'b0;
        sb.delete();

        // 2: full burst, ack tied high
        ack_mode = 0; spacing_on = 1'b1; first_word = 1'b1;
        w0 = words; f0 = fins;
        push_burst(10'h3FF);
        run_start(1'b0, '0, 10'h3FF);
        wait_fin("t2", n);
        @(posedge clk); #1;
        chk("t2_words", 32'(words - w0), 10);
        chk("t2_fins", 32'(fins - f0), 1);
        chk("t2_sb_empty", 32'(sb.size()), 0);
        chk("t2_ocupado_after", 32'(ocupado), 0);
        spacing_on = 1'b0;

        // 3: partial mask, delayed ack, data toggling while waiting
        ack_mode = 1;
        for (int i = 0; i < NR; i++) base[i*DW +: DW] = DW'(8'hA0 + 3 * i);
        in_datos_flat = base;
        w0 = words; f0 = fins;
        push_burst(10'b0000000111);
        run_start(1'b0, '0, 10'b0000000111);
        wait_fin("t3", n);
        chk("t3_words", 32'(words - w0), 3);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        chk("t3_fins", 32'(fins - f0), 1);

        // mask zero: full scan, no words
        ack_mode = 0;
        w0 = words;
        run_start(1'b0, '0, '0);
        wait_fin("mask0", n);
        chk("mask0_scan_cycles", 32'(n), NR);
        chk("mask0_words", 32'(words - w0), 0);

        // 4: single register 7
        base[7*DW +: DW] = 8'h45;
        in_datos_flat = base;
        w0 = words;
        sb.push_back({AW'(7), 8'h45});
        run_start(1'b1, AW'(7), '0);
        wait_fin("t4", n);
        chk("t4_words", 32'(words - w0), 1);
        chk("t4_err", 32'(error_addr), 0);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // 5: single out of range, sticky error cleared by next accepted start
        w0 = words;
        run_start(1'b1, AW'(12), '0);
        wait_fin("t5", n);
        chk("t5_fin_latency_ok", 32'(n <= 2), 1);
        chk("t5_err_set", 32'(error_addr), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_err_sticky", 32'(error_addr), 1);
        chk("t5_no_words", 32'(words - w0), 0);
        sb.push_back({AW'(7), 8'h45});
        run_start(1'b1, AW'(7), '0);
        chk("t5_err_cleared", 32'(error_addr), 0);
        wait_fin("t5b", n);
        chk("t5_sb_empty", 32'(sb.size()), 0);

        // 6: start during busy is ignored; ack while idle is ignored
        ack_mode = 1;
        for (int i = 0; i < NR; i++) base[i*DW +: DW] = DW'(8'h5C ^ (7 * i));
        in_datos_flat = base;
        w0 = words; f0 = fins;
        push_burst(10'h3FF);
        run_start(1'b0, '0, 10'h3FF);
        n = 0;
        while (words - w0 < 3 && n < 100) begin @(posedge clk); n++; end
        chk("t6_reached_word3", 32'(words - w0 >= 3), 1);
        run_start(1'b1, AW'(12), '0);
        chk("t6_err_unchanged", 32'(error_addr), 0);
        chk("t6_still_busy", 32'(ocupado), 1);
        wait_fin("t6", n);
        chk("t6_words", 32'(words - w0), 10);
        chk("t6_fins", 32'(fins - f0), 1);
        chk("t6_sb_empty", 32'(sb.size()), 0);
        chk("t6_err_after", 32'(error_addr), 0);
        ack_mode = 3;
        w0 = words; f0 = fins;
        repeat (2) @(negedge clk);
        rtc.in_ack = 1'b1;
        @(negedge clk);
        rtc.in_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_words", 32'(words - w0), 0);
        chk("t6_idle_fins", 32'(fins - f0), 0);
        chk("t6_idle_ocupado", 32'(ocupado), 0);
        chk("t6_idle_valid", 32'(rtc.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
